// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD HH:MM time-of-day counter with a one-second
// prescaler, a seconds counter, validated synchronous load and fully
// registered outputs for the alarm compare path.
module time_keeper #(
    parameter int CLK_DIV     = 50000000,
    parameter int SEC_PER_MIN = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] setData,
    output logic [15:0] timeData,
    output logic        secTick,
    output logic        minTick,
    output logic        loadErr
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(SEC_PER_MIN - 1);

    logic [PW-1:0] presc;
    logic [SW-1:0] sec_cnt;
    logic          second_edge;
    logic          minute_edge;
    logic          set_valid;
    logic          load_ok;

    // Advance HH:MM by one minute, keeping every digit within its legal range.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] ht, hu, mt, mu;
        {ht, hu, mt, mu} = t;
        if (mu != 4'd9) begin
            mu = mu + 4'd1;
        end else begin
            mu = 4'd0;
            if (mt != 4'd5) begin
                mt = mt + 4'd1;
            end else begin
                mt = 4'd0;
                if (ht == 4'd2 && hu == 4'd3) begin
                    ht = 4'd0;
                    hu = 4'd0;
                end else if (hu == 4'd9) begin
                    hu = 4'd0;
                    ht = ht + 4'd1;
                end else begin
                    hu = hu + 4'd1;
                end
            end
        end
        return {ht, hu, mt, mu};
    endfunction

    // Edge detection for the prescaler/seconds wraps and set-value validation.
    always_comb begin
        second_edge = run && (presc == PRESC_MAX);
        minute_edge = second_edge && (sec_cnt == SEC_MAX);
        set_valid   = (setData[15:12] <= 4'd2) &&
                      (setData[11:8]  <= 4'd9) &&
                      ((setData[15:12] != 4'd2) || (setData[11:8] <= 4'd3)) &&
                      (setData[7:4]   <= 4'd5) &&
                      (setData[3:0]   <= 4'd9);
        load_ok     = load && set_valid;
    end

    // Counters, time register and tick pulses; a valid load overrides any edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            sec_cnt  <= '0;
            timeData <= 16'h0000;
            secTick  <= 1'b0;
            minTick  <= 1'b0;
            loadErr  <= 1'b0;
        end else begin
            secTick <= 1'b0;
            minTick <= 1'b0;
            loadErr <= load && !set_valid;
            if (load_ok) begin
                timeData <= setData;
                presc    <= '0;
                sec_cnt  <= '0;
            end else if (run) begin
                if (second_edge) begin
                    presc   <= '0;
                    secTick <= 1'b1;
                    if (minute_edge) begin
                        sec_cnt  <= '0;
                        minTick  <= 1'b1;
                        timeData <= bcd_inc(timeData);
                    end else begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed bench for time_keeper with CLK_DIV=4 and
// SEC_PER_MIN=3, i.e. one minute every 12 run cycles.
module tb_time_keeper;

    logic        clk;
    logic        rst;
    logic        run;
    logic        load;
    logic [15:0] setData;
    logic [15:0] timeData;
    logic        secTick;
    logic        minTick;
    logic        loadErr;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] bad_vals [4];

    time_keeper #(.CLK_DIV(4), .SEC_PER_MIN(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .load     (load),
        .setData  (setData),
        .timeData (timeData),
        .secTick  (secTick),
        .minTick  (minTick),
        .loadErr  (loadErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bad_vals = '{16'h2400, 16'h0960, 16'h300A, 16'h0A00};
        rst = 1'b1;
        run = 1'b0;
        load = 1'b0;
        setData = 16'h0000;

        // Reset state
        cyc();
        cyc();
        check("rst_time", {16'h0, timeData}, 32'h0);
        check("rst_ticks", {29'h0, secTick, minTick, loadErr}, 32'h0);
        rst = 1'b0;
        run = 1'b1;

        // 1. Reset then run 12 cycles
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check($sformatf("t1_sec_%0d", i), {31'h0, secTick}, {31'h0, (i % 4 == 0)});
            check($sformatf("t1_min_%0d", i), {31'h0, minTick}, {31'h0, (i == 12)});
            check($sformatf("t1_time_%0d", i), {16'h0, timeData}, (i >= 12) ? 32'h0001 : 32'h0000);
        end

        // 2. Carry chain: 09:59->10:00
        load = 1'b1; setData = 16'h0959;
        cyc();
        load = 1'b0;
        check("t2a_load", {16'h0, timeData}, 32'h0959);
        repeat (11) cyc();
        check("t2a_pre_min", {31'h0, minTick}, 32'h0);
        cyc();
        check("t2a_min", {31'h0, minTick}, 32'h1);
        check("t2a_time", {16'h0, timeData}, 32'h1000);

        // 23:59->00:00
        load = 1'b1; setData = 16'h2359;
        cyc();
        load = 1'b0;
        check("t2b_load", {16'h0, timeData}, 32'h2359);
        repeat (12) cyc();
        check("t2b_time", {16'h0, timeData}, 32'h0000);
        check("t2b_min", {31'h0, minTick}, 32'h1);

        // 19:59->20:00
        load = 1'b1; setData = 16'h1959;
        cyc();
        load = 1'b0;
        repeat (12) cyc();
        check("t2c_time", {16'h0, timeData}, 32'h2000);

        // 3. Invalid loads, one per cycle, starting from a fresh minute
        for (int k = 1; k <= 4; k++) begin
            load = 1'b1; setData = bad_vals[k-1];
            cyc();
            check($sformatf("t3_err_%0d", k), {31'h0, loadErr}, 32'h1);
            check($sformatf("t3_time_%0d", k), {16'h0, timeData}, 32'h2000);
            check($sformatf("t3_sec_%0d", k), {31'h0, secTick}, {31'h0, (k == 4)});
        end
        load = 1'b0;
        cyc();
        check("t3_err_clear", {31'h0, loadErr}, 32'h0);
        repeat (3) cyc();
        check("t3_sec_8", {31'h0, secTick}, 32'h1);
        repeat (3) cyc();
        check("t3_pre_min", {31'h0, minTick}, 32'h0);
        cyc();
        check("t3_min", {31'h0, minTick}, 32'h1);
        check("t3_time", {16'h0, timeData}, 32'h2001);

        // 4. Valid load coincident with a minute edge
        repeat (11) cyc();
        load = 1'b1; setData = 16'h1234;
        cyc();
        load = 1'b0;
        check("t4_time", {16'h0, timeData}, 32'h1234);
        check("t4_ticks", {30'h0, secTick, minTick}, 32'h0);
        repeat (11) cyc();
        check("t4_pre_min", {31'h0, minTick}, 32'h0);
        check("t4_pre_time", {16'h0, timeData}, 32'h1234);
        cyc();
        check("t4_min", {30'h0, secTick, minTick}, 32'h3);
        check("t4_next", {16'h0, timeData}, 32'h1235);

        // 5. Freeze mid-second (prescaler at 2)
        repeat (2) cyc();
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check($sformatf("t5_freeze_%0d", i), {14'h0, secTick, minTick, timeData}, 32'h1235);
        end
        run = 1'b1;
        cyc();
        check("t5_resume_1", {31'h0, secTick}, 32'h0);
        cyc();
        check("t5_resume_2", {31'h0, secTick}, 32'h1);
        repeat (7) cyc();
        check("t5_pre_min", {31'h0, minTick}, 32'h0);
        cyc();
        check("t5_min", {31'h0, minTick}, 32'h1);
        check("t5_time", {16'h0, timeData}, 32'h1236);

        // 6. Async reset between edges at 12:34
        load = 1'b1; setData = 16'h1234;
        cyc();
        load = 1'b0;
        repeat (4) cyc();
        check("t6_setup", {15'h0, secTick, timeData}, 32'h11234);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async", {13'h0, secTick, minTick, loadErr, timeData}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (11) cyc();
        check("t6_pre_min", {31'h0, minTick}, 32'h0);
        cyc();
        check("t6_min", {31'h0, minTick}, 32'h1);
        check("t6_time", {16'h0, timeData}, 32'h0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day counter that produces the 16-bit BCD HH:MM value feeding the alarm clock's display/alarm multiplexer as `timeData`. It divides the system clock into one-second ticks, counts seconds into minutes, and advances a 24-hour BCD time with correct digit carries. The user's set value can be loaded synchronously; invalid set values are rejected and flagged. Outputs are fully registered, so the downstream equality compare against `alarmData` sees a glitch-free value.

## Interface
- `CLK_DIV`, default 50000000: clock cycles per second; legal range is 1 or greater.
- `SEC_PER_MIN`, default 60: seconds per minute; legal range is 1 or greater. Lowered only for simulation.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `run`  input  1  when 1, timekeeping advances; when 0, the prescaler, seconds and time freeze.
- `load`  input  1  single-cycle request to load `setData`.
- `setData`  input  16  BCD time [15:12]=hour tens, [11:8]=hour units, [7:4]=minute tens, [3:0]=minute units.
- `timeData`  output  16  current time, same BCD format as `setData`.
- `secTick`  output  1  one-cycle pulse per elapsed second.
- `minTick`  output  1  one-cycle pulse per minute rollover.
- `loadErr`  output  1  one-cycle pulse when a load is rejected.

## Operation
- **Reset values:** `timeData`=16'h0000, `secTick`=0, `minTick`=0, `loadErr`=0. The internal prescaler and seconds counter are both 0.
- **Prescaler:** binary counter, 0..CLK_DIV-1.
  - Increments when `run`=1.
  - Wraps to 0 at CLK_DIV-1; the wrap edge is the "second edge".
- **Seconds counter:** binary, 0..SEC_PER_MIN-1.
  - Increments on each second edge.
  - Wraps to 0 at SEC_PER_MIN-1; the wrap edge is the "minute edge".
- **Minute edge, BCD increment of `timeData`:**
  - Minute units 9 -> 0 with carry into minute tens.
  - Minute tens 5 -> 0 with carry into the hours.
  - Hours advance 09 -> 10 and 19 -> 20.
  - 23:59 -> 00:00.
  - Each digit only ever takes legal values.
- **Load validation:** `setData` is valid iff all of the following hold:
  - hour tens <= 2
  - hour units <= 9
  - if hour tens == 2, hour units <= 3
  - minute tens <= 5
  - minute units <= 9
- **Load behaviour:**
  - Valid load: at that edge, `timeData` <= `setData`; prescaler and seconds counter cleared to 0. No tick is generated for the load itself.
  - Invalid load: `timeData` unchanged; counters continue normally; `loadErr`=1 for the next cycle.
- **Priority:** `load` beats tick activity in the same cycle.
  - A valid load on a second or minute edge suppresses that increment and suppresses its `secTick`/`minTick`.
  - An invalid load does not suppress ticks.
- **`run`=0:** no ticks. A load is still accepted.
- **CLK_DIV=1:** every `run` cycle is a second edge.

## Timing
- `secTick` is registered: high for exactly the one cycle following a second edge.
- `minTick` is high for the one cycle following a minute edge, coincident with the first cycle the new `timeData` is visible. `secTick` is also high in that cycle.
- Increment latency: `timeData` changes on the same edge as the minute-edge condition, i.e. one register stage.
- Load latency: `timeData`=`setData` from the cycle after the `load` edge.
- First second edge after a valid load or reset occurs CLK_DIV `run` cycles later.
- First minute edge after a valid load or reset occurs CLK_DIV*SEC_PER_MIN `run` cycles later.
- Asserting `rst` mid-count immediately forces all reset values regardless of `clk`. Counting resumes from zero on the first edge after `rst` deasserts.
- `load` is level-sampled every edge. Holding it high reloads every cycle and so prevents advancement.

## Test plan
Parameter setting for all scenarios: CLK_DIV=4, SEC_PER_MIN=3, giving one minute per 12 `run` cycles.
1. **Reset, then run:** `run`=1 for 12 cycles after reset.
   - `secTick` pulses at cycles 4, 8 and 12.
   - `minTick` pulses at cycle 12.
   - `timeData`=16'h0001 from cycle 12.
2. **Carry chain:**
   - Load 16'h0959, run 12 cycles -> 16'h1000.
   - Load 16'h2359, run 12 cycles -> 16'h0000.
   - Load 16'h1959, run 12 cycles -> 16'h2000.
3. **Invalid loads:** 16'h2400, 16'h0960, 16'h300A and 16'h0A00.
   - `loadErr` pulses once per load.
   - `timeData` unchanged.
   - Tick cadence unaffected.
4. **Load on a minute edge:** valid load of 16'h1234 coincident with a minute edge.
   - `timeData`=16'h1234, not 16'h1235.
   - No `minTick` or `secTick`.
   - Next `minTick` arrives 12 cycles later with `timeData`=16'h1235.
5. **Freeze:** drop `run` for 20 cycles mid-second.
   - No ticks while `run`=0; `timeData` stable.
   - On resume, the remaining prescaler count completes exactly.
6. **Async reset mid-count:** pulse `rst` between clock edges at `timeData`=16'h1234.
   - Outputs go to 0 immediately.
   - Next `minTick` arrives 12 `run` cycles after `rst` deasserts.
